// File: rtl/gray_bin.sv
// rtl/gray_bin.sv - registered Gray<->binary converter with Gray adjacency checker
module gray_bin #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic             step_err
);

  logic [WIDTH-1:0] prev_a;
  logic             hist_v;
  logic [WIDTH-1:0] bin_word;
  logic [WIDTH-1:0] gray_word;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_word[i] = ^(a >> i);
    end
  end

  assign gray_word = a ^ (a >> 1);
  assign diff      = a ^ prev_a;
  // Clearing the lowest set bit leaves something only if two or more bits differ.
  assign multi_bit = |(diff & (diff - WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      c         <= '0;
      out_valid <= 1'b0;
      step_err  <= 1'b0;
      prev_a    <= '0;
      hist_v    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        c        <= mode ? gray_word : bin_word;
        step_err <= !mode && hist_v && multi_bit;
        if (!mode) begin
          prev_a <= a;
          hist_v <= 1'b1;
        end else begin
          hist_v <= 1'b0;
        end
      end else begin
        step_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_bin.sv
// tb/tb_gray_bin.sv - randomized self-checking bench for gray_bin
module tb_gray_bin;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] c;
  logic         out_valid;
  logic         step_err;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [W-1:0] m_prev;
  logic         m_hv;
  logic [W-1:0] exp_c;
  logic         exp_ov;
  logic         exp_se;

  gray_bin #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
    .a(a), .c(c), .out_valid(out_valid), .step_err(step_err)
  );

  always #5 clk = ~clk;

  // binary value whose Gray encoding equals g, found by search
  function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
    logic [W-1:0] n;
    gray_to_bin = '0;
    for (int k = 0; k < (1 << W); k++) begin
      n = W'(k);
      if ((n ^ (n >> 1)) == g) gray_to_bin = n;
    end
  endfunction

  task automatic step(input logic r, input logic v, input logic m, input logic [W-1:0] val);
    rst = r; in_valid = v; mode = m; a = val;
    @(posedge clk);
    #1;
    if (r) begin
      exp_c = '0; exp_ov = 1'b0; exp_se = 1'b0; m_prev = '0; m_hv = 1'b0;
    end else begin
      exp_ov = v;
      if (v) begin
        exp_c  = m ? (val ^ (val >> 1)) : gray_to_bin(val);
        exp_se = !m && m_hv && ($countones(val ^ m_prev) >= 2);
        if (!m) begin m_prev = val; m_hv = 1'b1; end
        else m_hv = 1'b0;
      end else begin
        exp_se = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0, 4'b1111);
    checks++;
    if (c !== 4'b0000 || out_valid !== 1'b0 || step_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: c=%b ov=%b se=%b required c=0000 ov=0 se=0", c, out_valid, step_err);
    end
  endtask

  task automatic test_g2b_sweep();
    logic [W-1:0] val;
    for (int i = 0; i < 16; i++) begin
      val = W'(i);
      step(1'b0, 1'b1, 1'b0, val);
      checks++;
      if (c !== exp_c || out_valid !== 1'b1 || step_err !== exp_se) begin
        errors++;
        $display("FAIL g2b_sweep a=%b: c=%b ov=%b se=%b required c=%b ov=1 se=%b",
                 val, c, out_valid, step_err, exp_c, exp_se);
      end
      if (i == 6 || i == 8 || i == 15) begin
        checks++;
        if (c !== (i == 6 ? 4'b0100 : i == 8 ? 4'b1111 : 4'b1010)) begin
          errors++;
          $display("FAIL g2b_point a=%b: c=%b", val, c);
        end
      end
      if (i == 1 || i == 2 || i == 4) begin
        checks++;
        if (step_err !== (i != 1)) begin
          errors++;
          $display("FAIL g2b_step a=%b: se=%b required %b", val, step_err, i != 1);
        end
      end
    end
  endtask

  task automatic test_b2g();
    step(1'b0, 1'b1, 1'b1, 4'b0111);
    checks++;
    if (c !== 4'b0100 || step_err !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2g_0111: c=%b se=%b ov=%b required c=0100 se=0 ov=1", c, step_err, out_valid);
    end
    step(1'b0, 1'b1, 1'b1, 4'b1111);
    checks++;
    if (c !== 4'b1000 || step_err !== 1'b0) begin
      errors++;
      $display("FAIL b2g_1111: c=%b se=%b required c=1000 se=0", c, step_err);
    end
  endtask

  task automatic test_adjacency();
    logic [W-1:0] seq [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0101};
    logic         req [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, seq[i]);
      checks++;
      if (step_err !== req[i] || c !== exp_c) begin
        errors++;
        $display("FAIL adjacency a=%b: se=%b c=%b required se=%b c=%b", seq[i], step_err, c, req[i], exp_c);
      end
    end
  endtask

  task automatic test_gaps(input logic insert_b2g);
    step(1'b0, 1'b1, 1'b0, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      if (insert_b2g && i == 1) begin
        step(1'b0, 1'b1, 1'b1, 4'b1010);
      end else begin
        step(1'b0, 1'b0, 1'b0, 4'($urandom));
        if (!insert_b2g) begin
          checks++;
          if (c !== 4'b0010 || out_valid !== 1'b0 || step_err !== 1'b0) begin
            errors++;
            $display("FAIL gap_hold: c=%b ov=%b se=%b required c=0010 ov=0 se=0", c, out_valid, step_err);
          end
        end
      end
    end
    step(1'b0, 1'b1, 1'b0, insert_b2g ? 4'b1100 : 4'b0010);
    checks++;
    if (step_err !== 1'b0 || out_valid !== 1'b1 || c !== exp_c) begin
      errors++;
      $display("FAIL gap_after mode_gap=%b: se=%b ov=%b c=%b required se=0 ov=1 c=%b",
               insert_b2g, step_err, out_valid, c, exp_c);
    end
  endtask

  task automatic test_midstream_reset();
    step(1'b0, 1'b1, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 1'b0, 4'b0101);
    checks++;
    if (c !== 4'b0000 || out_valid !== 1'b0 || step_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: c=%b ov=%b se=%b required 0000 0 0", c, out_valid, step_err);
    end
    step(1'b0, 1'b1, 1'b0, 4'b1111);
    checks++;
    if (step_err !== 1'b0 || c !== 4'b1010) begin
      errors++;
      $display("FAIL after_reset: se=%b c=%b required se=0 c=1010", step_err, c);
    end
  endtask

  task automatic test_random();
    logic r, v, m;
    logic [W-1:0] val;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 29) == 0);
      v   = ($urandom_range(0, 3) != 0);
      m   = ($urandom_range(0, 3) == 0);
      val = ($urandom_range(0, 1) == 0) ? (m_prev ^ W'(1 << $urandom_range(0, W - 1))) : W'($urandom);
      step(r, v, m, val);
      checks++;
      if (c !== exp_c || out_valid !== exp_ov || step_err !== exp_se) begin
        errors++;
        $display("FAIL random r=%b v=%b m=%b a=%b: c=%b ov=%b se=%b required c=%b ov=%b se=%b",
                 r, v, m, val, c, out_valid, step_err, exp_c, exp_ov, exp_se);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; a = '0;
    m_prev = '0; m_hv = 1'b0; exp_c = '0; exp_ov = 1'b0; exp_se = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_g2b_sweep();
    test_b2g();
    test_adjacency();
    test_gaps(1'b0);
    test_gaps(1'b1);
    test_midstream_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
